// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: hh:mm:ss register owner for the 24 h clock.
// It advances time on tick_1hz in RUN. Three keys step the set mode and
// increment or decrement the selected field. The per-field blank flags make
// the field being set blink on the display.
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned HOUR_MAX      = 23
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic [2:0] blank
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] SET_HR  = 2'd1;
  localparam logic [1:0] SET_MIN = 2'd2;
  localparam logic [1:0] SET_SEC = 2'd3;

  localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [5:0] HMAX = 6'(HOUR_MAX);
  localparam logic [5:0] MMAX = 6'd59;

  // Key bit order: [2]=mode [1]=inc [0]=dec
  logic [2:0] key_s1, key_s2, key_s3, key_pulse;
  logic       mode_p, inc_p, dec_p;

  logic [CW-1:0] count, count_n;
  logic          phase, phase_n;
  logic [1:0]    mode_n;
  logic [4:0]    hour_n;
  logic [5:0]    minute_n, second_n;
  logic [2:0]    blank_n;
  logic          inc_only, dec_only;

  // Wrapping single-field step, used for setting; never carries.
  function automatic logic [5:0] step(input logic [5:0] v,
                                      input logic [5:0] vmax,
                                      input logic       up);
    if (up) step = (v == vmax) ? 6'd0 : v + 6'd1;
    else    step = (v == 6'd0) ? vmax : v - 6'd1;
  endfunction

  // Two-flop synchronizer, edge detector and registered one-cycle pulse.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      key_s1    <= '0;
      key_s2    <= '0;
      key_s3    <= '0;
      key_pulse <= '0;
    end else begin
      key_s1    <= {key_mode, key_inc, key_dec};
      key_s2    <= key_s1;
      key_s3    <= key_s2;
      key_pulse <= key_s2 & ~key_s3;
    end
  end

  assign mode_p   = key_pulse[2];
  assign inc_p    = key_pulse[1];
  assign dec_p    = key_pulse[0];
  assign inc_only = inc_p & ~dec_p;
  assign dec_only = dec_p & ~inc_p;

  // Next-state logic for mode, timeout, blink phase and time fields.
  always_comb begin
    mode_n   = mode;
    count_n  = count;
    phase_n  = phase;
    hour_n   = hour;
    minute_n = minute;
    second_n = second;

    if (tick_2hz) phase_n = ~phase;

    if (mode_p) begin
      // Mode key wins over inc/dec and over a coincident timeout expiry.
      unique case (mode)
        RUN:     mode_n = SET_HR;
        SET_HR:  mode_n = SET_MIN;
        SET_MIN: mode_n = SET_SEC;
        default: mode_n = RUN;
      endcase
      count_n = '0;
      if (mode_n != RUN) phase_n = 1'b0;
    end else if (mode != RUN) begin
      if (inc_p || dec_p) begin
        count_n = '0;
        if (inc_only || dec_only) begin
          unique case (mode)
            SET_HR:  hour_n   = 5'(step({1'b0, hour}, HMAX, inc_only));
            SET_MIN: minute_n = step(minute, MMAX, inc_only);
            default: second_n = step(second, MMAX, inc_only);
          endcase
        end
      end else if (tick_1hz) begin
        if (count == CW'(TIMEOUT_TICKS - 1)) begin
          mode_n  = RUN;
          count_n = '0;
        end else begin
          count_n = count + CW'(1);
        end
      end
    end

    // Full carry chain resolves in one edge, e.g. 23:59:59 -> 00:00:00.
    if (mode == RUN && tick_1hz) begin
      if (second == MMAX) begin
        second_n = '0;
        if (minute == MMAX) begin
          minute_n = '0;
          hour_n   = ({1'b0, hour} == HMAX) ? 5'd0 : hour + 5'd1;
        end else begin
          minute_n = minute + 6'd1;
        end
      end else begin
        second_n = second + 6'd1;
      end
    end

    blank_n = phase_n ? {mode_n == SET_HR, mode_n == SET_MIN, mode_n == SET_SEC}
                      : 3'b000;
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      mode   <= RUN;
      count  <= '0;
      phase  <= 1'b0;
      hour   <= '0;
      minute <= '0;
      second <= '0;
      blank  <= '0;
    end else begin
      mode   <= mode_n;
      count  <= count_n;
      phase  <= phase_n;
      hour   <= hour_n;
      minute <= minute_n;
      second <= second_n;
      blank  <= blank_n;
    end
  end

endmodule
